// File: rtl/branch_resolve_unit.sv
// Registered branch resolution stage: evaluates RV32I/RV64I conditional branches,
// produces the redirect PC and misprediction flags behind a one-deep valid/ready register.
module branch_resolve_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  rs1,
   input  logic [XLEN-1:0]  rs2,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  pc,
   input  logic [XLEN-1:0]  imm,
   input  logic             pred_taken,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             taken,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             mispredict,
   output logic             misalign,
   output logic             illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   function automatic logic branch_cond(input logic [2:0] f3, input logic eq,
                                        input logic lt, input logic ltu);
      logic c;
      case (f3)
         3'b000:  c = eq;
         3'b001:  c = !eq;
         3'b100:  c = lt;
         3'b101:  c = !lt;
         3'b110:  c = ltu;
         3'b111:  c = !ltu;
         default: c = 1'b0;
      endcase
      return c;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + CNT_W'(1'b1);
      end
      return r;
   endfunction

   logic            eq_s, lt_s, ltu_s, legal_s, taken_s, mispredict_s, misalign_s, accept_s;
   logic [XLEN-1:0] target_s, seq_s, redirect_s;

   logic            out_valid_r, taken_r, mispredict_r, misalign_r, illegal_r;
   logic [XLEN-1:0] redirect_r;
   logic [CNT_W-1:0] branch_cnt_r, mispred_cnt_r;

   // Branch condition evaluation and result field computation for the incoming request.
   always_comb begin
      eq_s         = 1'b0;
      lt_s         = 1'b0;
      ltu_s        = 1'b0;
      legal_s      = 1'b0;
      taken_s      = 1'b0;
      target_s     = '0;
      seq_s        = '0;
      redirect_s   = '0;
      mispredict_s = 1'b0;
      misalign_s   = 1'b0;

      eq_s     = (rs1 == rs2);
      lt_s     = ($signed(rs1) < $signed(rs2));
      ltu_s    = (rs1 < rs2);
      legal_s  = (funct3[2:1] != 2'b01);
      target_s = pc + imm;
      seq_s    = pc + XLEN'(3'd4);
      taken_s  = legal_s && branch_cond(funct3, eq_s, lt_s, ltu_s);
      if (taken_s) begin
         redirect_s = target_s;
      end else begin
         redirect_s = seq_s;
      end
      mispredict_s = legal_s && (taken_s != pred_taken);
      misalign_s   = taken_s && (target_s[1:0] != 2'b00);
   end

   assign in_ready = !out_valid_r || out_ready;
   assign accept_s = in_valid && in_ready && !flush;

   // Result register: flush beats accept, and a plain handshake only drops out_valid.
   always_ff @(posedge CLK) begin
      if (RST) begin
         out_valid_r  <= 1'b0;
         taken_r      <= 1'b0;
         redirect_r   <= '0;
         mispredict_r <= 1'b0;
         misalign_r   <= 1'b0;
         illegal_r    <= 1'b0;
      end else if (accept_s) begin
         out_valid_r  <= 1'b1;
         taken_r      <= taken_s;
         redirect_r   <= redirect_s;
         mispredict_r <= mispredict_s;
         misalign_r   <= misalign_s;
         illegal_r    <= !legal_s;
      end else if (flush || out_ready) begin
         out_valid_r  <= 1'b0;
      end else begin
         out_valid_r  <= out_valid_r;
      end
   end

   // Saturating performance counters; clear wins over a same-cycle increment.
   always_ff @(posedge CLK) begin
      if (RST || cnt_clr) begin
         branch_cnt_r  <= '0;
         mispred_cnt_r <= '0;
      end else if (accept_s && legal_s) begin
         branch_cnt_r <= sat_inc(branch_cnt_r);
         if (mispredict_s) begin
            mispred_cnt_r <= sat_inc(mispred_cnt_r);
         end else begin
            mispred_cnt_r <= mispred_cnt_r;
         end
      end else begin
         branch_cnt_r  <= branch_cnt_r;
         mispred_cnt_r <= mispred_cnt_r;
      end
   end

   assign out_valid   = out_valid_r;
   assign taken       = taken_r;
   assign redirect_pc = redirect_r;
   assign mispredict  = mispredict_r;
   assign misalign    = misalign_r;
   assign illegal     = illegal_r;
   assign branch_cnt  = branch_cnt_r;
   assign mispred_cnt = mispred_cnt_r;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors with hand-computed results,
// checked by an independent output monitor.
module tb_branch_resolve_unit;

   logic        CLK = 1'b0;
   logic        RST, in_valid, in_ready, pred_taken, flush, out_valid, out_ready;
   logic        taken, mispredict, misalign, illegal, cnt_clr;
   logic [31:0] rs1, rs2, pc, imm, redirect_pc;
   logic [2:0]  funct3;
   logic [15:0] branch_cnt, mispred_cnt;

   typedef struct packed {
      logic        tk;
      logic [31:0] rd;
      logic        mp;
      logic        ma;
      logic        il;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 CLK = ~CLK;

   branch_resolve_unit #(.XLEN(32), .CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
      .rs1(rs1), .rs2(rs2), .funct3(funct3), .pc(pc), .imm(imm),
      .pred_taken(pred_taken), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .taken(taken), .redirect_pc(redirect_pc),
      .mispredict(mispredict), .misalign(misalign), .illegal(illegal),
      .cnt_clr(cnt_clr), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every completed output handshake is compared against the oldest expectation.
   always @(negedge CLK) begin
      exp_t e;
      if (!RST && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got redirect 0x%0h expected no output", redirect_pc);
         end else begin
            e = sb.pop_front();
            chk("taken", {63'd0, taken}, {63'd0, e.tk});
            chk("redirect_pc", {32'd0, redirect_pc}, {32'd0, e.rd});
            chk("mispredict", {63'd0, mispredict}, {63'd0, e.mp});
            chk("misalign", {63'd0, misalign}, {63'd0, e.ma});
            chk("illegal", {63'd0, illegal}, {63'd0, e.il});
         end
      end
   end

   task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [31:0] i, input logic pt,
                       input logic e_tk, input logic [31:0] e_rd, input logic e_mp,
                       input logic e_ma, input logic e_il);
      int n;
      exp_t e;
      funct3 = f3; rs1 = a; rs2 = b; pc = p; imm = i; pred_taken = pt;
      in_valid = 1'b1;
      n = 0;
      while (1) begin
         @(negedge CLK);
         if (in_ready) break;
         n++;
         if (n > 100) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1 within 100 cycles");
            in_valid = 1'b0;
            return;
         end
      end
      e.tk = e_tk; e.rd = e_rd; e.mp = e_mp; e.ma = e_ma; e.il = e_il;
      sb.push_back(e);
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_cnt(input string nm, input logic [15:0] eb, input logic [15:0] em);
      chk({nm, "_branch_cnt"}, {48'd0, branch_cnt}, {48'd0, eb});
      chk({nm, "_mispred_cnt"}, {48'd0, mispred_cnt}, {48'd0, em});
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_out_valid"}, {63'd0, out_valid}, 64'd0);
      chk({nm, "_taken"}, {63'd0, taken}, 64'd0);
      chk({nm, "_redirect"}, {32'd0, redirect_pc}, 64'd0);
      chk({nm, "_mispredict"}, {63'd0, mispredict}, 64'd0);
      chk({nm, "_misalign"}, {63'd0, misalign}, 64'd0);
      chk({nm, "_illegal"}, {63'd0, illegal}, 64'd0);
      chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd1);
      chk_cnt(nm, 16'd0, 16'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
      rs1 = 32'd0; rs2 = 32'd0; pc = 32'd0; imm = 32'd0; funct3 = 3'd0; pred_taken = 1'b0;
      idle(2);
      RST = 1'b0;
      @(negedge CLK);
      chk_zero("reset");
      @(posedge CLK); #1;

      // Basic BEQ taken, predicted not-taken.
      send(3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b0, 1'b1, 32'h120, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk_cnt("beq", 16'd1, 16'd1);
      @(posedge CLK); #1;

      // Signed vs unsigned and the remaining branch types.
      send(3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b1, 32'h240, 1'b0, 1'b0, 1'b0);
      send(3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b0, 32'h204, 1'b1, 1'b0, 1'b0);
      send(3'b111, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h40, 1'b0, 1'b1, 32'h240, 1'b1, 1'b0, 1'b0);
      send(3'b001, 32'h3, 32'h4, 32'h300, 32'hFFFFFFF0, 1'b1, 1'b1, 32'h2F0, 1'b0, 1'b0, 1'b0);
      send(3'b101, 32'h1, 32'hFFFFFFFF, 32'h400, 32'h8, 1'b0, 1'b1, 32'h408, 1'b1, 1'b0, 1'b0);
      send(3'b000, 32'h1, 32'h2, 32'h500, 32'h10, 1'b0, 1'b0, 32'h504, 1'b0, 1'b0, 1'b0);
      @(negedge CLK);
      chk_cnt("types", 16'd7, 16'd4);
      @(posedge CLK); #1;

      // Illegal funct3 values leave the counters alone.
      send(3'b010, 32'h9, 32'h9, 32'h600, 32'h10, 1'b1, 1'b0, 32'h604, 1'b0, 1'b0, 1'b1);
      send(3'b011, 32'h9, 32'h8, 32'h610, 32'h10, 1'b0, 1'b0, 32'h614, 1'b0, 1'b0, 1'b1);
      @(negedge CLK);
      chk_cnt("illegal", 16'd7, 16'd4);
      @(posedge CLK); #1;

      // Misaligned target, then PC wrap-around.
      send(3'b000, 32'h0, 32'h0, 32'h700, 32'h2, 1'b1, 1'b1, 32'h702, 1'b0, 1'b1, 1'b0);
      send(3'b000, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h8, 1'b1, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
      idle(2);
      chk_cnt("wrap", 16'd9, 16'd4);

      // Backpressure: first result must hold while two more requests wait.
      send(3'b000, 32'h1, 32'h1, 32'h1000, 32'h10, 1'b1, 1'b1, 32'h1010, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b0;
      fork
         begin
            send(3'b110, 32'h1, 32'h2, 32'h1100, 32'h20, 1'b0, 1'b1, 32'h1120, 1'b1, 1'b0, 1'b0);
            send(3'b101, 32'h2, 32'h5, 32'h1200, 32'h30, 1'b0, 1'b0, 32'h1204, 1'b0, 1'b0, 1'b0);
         end
         begin
            repeat (3) begin
               @(negedge CLK);
               chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
               chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
               chk("bp_redirect", {32'd0, redirect_pc}, 64'h1010);
            end
            @(posedge CLK); #1;
            out_ready = 1'b1;
         end
      join
      idle(3);
      chk("bp_drained", 64'(sb.size()), 64'd0);
      chk_cnt("bp", 16'd12, 16'd5);

      // Flush with a same-cycle request: the request is dropped and not counted.
      send(3'b000, 32'h7, 32'h7, 32'h2000, 32'h100, 1'b1, 1'b1, 32'h2100, 1'b0, 1'b0, 1'b0);
      funct3 = 3'b000; rs1 = 32'h3; rs2 = 32'h3; pc = 32'h2200; imm = 32'h8; pred_taken = 1'b0;
      in_valid = 1'b1; flush = 1'b1;
      @(posedge CLK); #1;
      in_valid = 1'b0; flush = 1'b0;
      @(negedge CLK);
      chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
      chk_cnt("flush", 16'd13, 16'd5);
      @(posedge CLK); #1;

      // Clear coincident with an accept.
      cnt_clr = 1'b1;
      send(3'b000, 32'h0, 32'h0, 32'h3000, 32'h4, 1'b0, 1'b1, 32'h3004, 1'b1, 1'b0, 1'b0);
      cnt_clr = 1'b0;
      @(negedge CLK);
      chk_cnt("clr", 16'd0, 16'd0);
      @(posedge CLK); #1;

      // Drive both counters to saturation and past it.
      for (int k = 0; k < 65535; k++) begin
         send(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4 - 32'h4, 1'b1, 1'b0, 1'b0);
      end
      @(negedge CLK);
      chk_cnt("sat_reach", 16'hFFFF, 16'hFFFF);
      @(posedge CLK); #1;
      send(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
      send(3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      chk_cnt("sat_hold", 16'hFFFF, 16'hFFFF);
      @(posedge CLK); #1;

      // Reset while a result is pending, together with clear and flush.
      idle(2);
      out_ready = 1'b0;
      send(3'b001, 32'h1, 32'h2, 32'h4000, 32'h24, 1'b0, 1'b1, 32'h4024, 1'b1, 1'b0, 1'b0);
      RST = 1'b1; cnt_clr = 1'b1; flush = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0; cnt_clr = 1'b0; flush = 1'b0;
      sb.delete();
      @(negedge CLK);
      chk_zero("midrst");
      out_ready = 1'b1;
      idle(3);
      chk("final_drained", 64'(sb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
